// File: rtl/clock_period_meter.sv
// Measures clk cycles between successive edges of an asynchronous in_sig and offers the result
// through a valid/ready handshake. Optional stall timeout: define CLOCK_PERIOD_METER_TIMEOUT_EN.
module clock_period_meter #(
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_sig,
  input  logic            ready,
  output logic [BITS-1:0] half_period,
  output logic            valid,
  output logic            overrun,
  output logic            stalled
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam logic [BITS-1:0] CNT_MAX = '1;

  logic            sync1_q, sync2_q, prev_q;
  logic            edge_det;
  state_e          state_q, state_d;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] cnt_inc;
  logic [BITS-1:0] hp_q, hp_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            capture, count_en, timeout;

  // Two flops absorb metastability on in_sig; prev_q is the reference level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value -- a true shift chain.
      sync1_q <= in_sig;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_det = sync2_q ^ prev_q;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + BITS'(1);

`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
  // Give up once the counter has sat at its ceiling for a full cycle with no edge.
  assign timeout = (state_q == MEASURE) && !edge_det && (cnt_q == CNT_MAX);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first, so no path through this block leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (edge_det) state_d = MEASURE;
      MEASURE: if (timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture  = 1'b0;
    count_en = 1'b0;
    case (state_q)
      MEASURE: begin
        capture  = edge_det;
        count_en = !edge_det && !timeout;
      end
      default: begin
        capture  = 1'b0;
        count_en = 1'b0;
      end
    endcase
  end

  // The counter is zero in IDLE, on every edge and on timeout; it only climbs between edges.
  always_comb begin
    cnt_d = '0;
    if (count_en) begin
      cnt_d = cnt_inc;
    end
  end

  always_comb begin
    hp_d    = hp_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (capture) begin
      hp_d    = cnt_inc;
      valid_d = 1'b1;
      if (valid_q) begin
        ovr_d = !ready;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      hp_q    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
  logic stall_q, stall_d;

  // Stalled persists through IDLE until the next edge restarts measurement.
  always_comb begin
    stall_d = stall_q;
    if (timeout) begin
      stall_d = 1'b1;
    end else if ((state_q == IDLE) && edge_det) begin
      stall_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stalled = stall_q;
`else
  assign stalled = 1'b0;
`endif

  assign half_period = hp_q;
  assign valid       = valid_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter: BITS=8 and BITS=4 instances against a
// timestamp-based reference model, plus directed literal checks.
module tb_clock_period_meter;

`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in0, in1, rdy0, rdy1;
  logic [7:0] hp0;
  logic [3:0] hp1;
  logic       vld0, vld1, ovr0, ovr1, stl0, stl1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clock_period_meter #(.BITS(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_sig(in0), .ready(rdy0),
    .half_period(hp0), .valid(vld0), .overrun(ovr0), .stalled(stl0)
  );

  clock_period_meter #(.BITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_sig(in1), .ready(rdy1),
    .half_period(hp1), .valid(vld1), .overrun(ovr1), .stalled(stl1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each level change first sampled at posedge s is reported at posedge s+2;
  // a reported edge's half period is the posedge distance to the previous reported edge.
  int maxv [2] = '{255, 15};
  int cyc = 0;
  int pend0[$];
  int pend1[$];
  bit m_meas [2];
  bit m_valid [2];
  bit m_ovr [2];
  bit m_stall [2];
  bit m_lvl [2];
  int m_hp [2];
  int m_last [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_meas[k]  = 1'b0;
      m_valid[k] = 1'b0;
      m_ovr[k]   = 1'b0;
      m_stall[k] = 1'b0;
      m_lvl[k]   = 1'b0;
      m_hp[k]    = 0;
      m_last[k]  = 0;
    end
    pend0.delete();
    pend1.delete();
  endtask

  task automatic model_step(input int k, input bit in_v, input bit rdy);
    bit have;
    int front;
    int gap;
    have  = (k == 0) ? (pend0.size() > 0) : (pend1.size() > 0);
    front = 0;
    if (have) front = (k == 0) ? pend0[0] : pend1[0];
    if (have && (front + 2 == cyc)) begin
      if (k == 0) void'(pend0.pop_front());
      else        void'(pend1.pop_front());
      if (!m_meas[k]) begin
        m_meas[k]  = 1'b1;
        m_stall[k] = 1'b0;
        m_last[k]  = cyc;
      end else begin
        gap     = cyc - m_last[k];
        m_hp[k] = (gap > maxv[k]) ? maxv[k] : gap;
        if (m_valid[k]) m_ovr[k] = !rdy;
        m_valid[k] = 1'b1;
        m_last[k]  = cyc;
      end
    end else begin
      if (m_valid[k] && rdy) begin
        m_valid[k] = 1'b0;
        m_ovr[k]   = 1'b0;
      end
      if (TMO && m_meas[k] && (cyc - m_last[k] == maxv[k] + 1)) begin
        m_meas[k]  = 1'b0;
        m_stall[k] = 1'b1;
      end
    end
    if (in_v != m_lvl[k]) begin
      if (k == 0) pend0.push_back(cyc);
      else        pend1.push_back(cyc);
      m_lvl[k] = in_v;
    end
  endtask

  // Model advance and full-output compare on every clock.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        model_step(0, in0, rdy0);
        model_step(1, in1, rdy1);
      end
      #1;
      check("hp0",  32'(hp0),  32'(m_hp[0]));
      check("vld0", 32'(vld0), 32'(m_valid[0]));
      check("ovr0", 32'(ovr0), 32'(m_ovr[0]));
      check("stl0", 32'(stl0), 32'(m_stall[0]));
      check("hp1",  32'(hp1),  32'(m_hp[1]));
      check("vld1", 32'(vld1), 32'(m_valid[1]));
      check("ovr1", 32'(ovr1), 32'(m_ovr[1]));
      check("stl1", 32'(stl1), 32'(m_stall[1]));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic tog(input int k, input int n);
    repeat (n) @(negedge clk);
    if (k == 0) in0 = ~in0;
    else        in1 = ~in1;
  endtask

  // Toggle inst0 after n cycles and hold ready high exactly on the resulting capture edge.
  task automatic tog_ready_at_capture(input int n);
    tog(0, n);
    repeat (2) @(negedge clk);
    rdy0 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
  endtask

  int done_cnt;

  initial begin
    rst = 1'b1; in0 = 1'b0; in1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hp0", 32'(hp0), 0);
    check("rst_vld0", 32'(vld0), 0);
    check("rst_stl1", 32'(stl1), 0);
    rst = 1'b0;

    // N=16 with ready held high: first edge silent, then one-cycle valid pulses of 16.
    rdy0 = 1'b1;
    tog(0, 4);
    repeat (3) @(negedge clk);
    check("first_edge_vld", 32'(vld0), 0);
    check("first_edge_hp", 32'(hp0), 0);
    tog(0, 13);
    repeat (3) tog(0, 16);
    repeat (3) @(negedge clk);
    check("n16_hp", 32'(hp0), 16);
    check("n16_vld", 32'(vld0), 1);
    check("n16_ovr", 32'(ovr0), 0);
    @(negedge clk);
    check("n16_pulse_end", 32'(vld0), 0);

    // N=5 with ready low: result held, overrun from the second capture, one ready cycle clears.
    rdy0 = 1'b0;
    repeat (3) tog(0, 5);
    repeat (3) @(negedge clk);
    check("n5_hp", 32'(hp0), 5);
    check("n5_vld", 32'(vld0), 1);
    check("n5_ovr", 32'(ovr0), 1);
    rdy0 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
    check("ack_vld", 32'(vld0), 0);
    check("ack_ovr", 32'(ovr0), 0);

    // Capture coincident with ready while valid is set.
    tog(0, 7);
    tog_ready_at_capture(9);
    check("coinc_hp", 32'(hp0), 9);
    check("coinc_vld", 32'(vld0), 1);
    check("coinc_ovr", 32'(ovr0), 0);
    tog(0, 4);
    repeat (3) @(negedge clk);
    check("ovr_set_hp", 32'(hp0), 7);
    check("ovr_set", 32'(ovr0), 1);
    tog_ready_at_capture(3);
    check("coinc2_hp", 32'(hp0), 6);
    check("coinc2_vld", 32'(vld0), 1);
    check("coinc2_ovr_clr", 32'(ovr0), 0);

    // N=1: in_sig changes every clk.
    rdy0 = 1'b1;
    repeat (12) tog(0, 1);
    repeat (3) @(negedge clk);
    check("n1_hp", 32'(hp0), 1);
    check("n1_vld", 32'(vld0), 1);

    // BITS=4: hold 20 clk, then toggle.
    rdy1 = 1'b1;
    tog(1, 5);
    tog(1, 5);
    repeat (19) @(negedge clk);
    check("b4_stalled", 32'(stl1), 32'(TMO));
    @(negedge clk);
    in1 = ~in1;
    repeat (3) @(negedge clk);
    check("b4_stl_after", 32'(stl1), 0);
    check("b4_vld_after", 32'(vld1), TMO ? 0 : 1);
    check("b4_hp_after", 32'(hp1), TMO ? 5 : 15);
    tog(1, 5);
    tog(1, 5);

    // Async reset mid-measurement.
    rdy0 = 1'b0;
    repeat (3) tog(0, 8);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1; in0 = 1'b0; in1 = 1'b0;
    model_reset();
    #1;
    check("arst_hp0", 32'(hp0), 0);
    check("arst_vld0", 32'(vld0), 0);
    check("arst_ovr0", 32'(ovr0), 0);
    check("arst_stl0", 32'(stl0), 0);
    check("arst_hp1", 32'(hp1), 0);
    check("arst_vld1", 32'(vld1), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdy0 = 1'b1;
    tog(0, 8);
    repeat (3) @(negedge clk);
    check("post_rst_first_vld", 32'(vld0), 0);
    check("post_rst_first_hp", 32'(hp0), 0);
    tog(0, 5);
    repeat (3) @(negedge clk);
    check("post_rst_second_hp", 32'(hp0), 8);
    check("post_rst_second_vld", 32'(vld0), 1);

    // Randomized toggling and ready on both instances, including saturating gaps.
    done_cnt = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          tog(0, ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 262))
                                             : int'($urandom_range(1, 12)));
        end
        done_cnt++;
      end
      begin
        for (int i = 0; i < 200; i++) begin
          tog(1, int'($urandom_range(1, 22)));
        end
        done_cnt++;
      end
      begin
        while (done_cnt < 2) begin
          @(negedge clk);
          rdy0 = 1'($urandom_range(0, 1));
          rdy1 = 1'($urandom_range(0, 1));
        end
      end
    join
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
